// File: rtl/tmds_video_pkg.sv
// tmds_video_pkg: shared types for the TMDS raster timing controller.
// Region encoding, region-length bundle, next-region helper and the
// control-period symbols the channel encoders emit during blanking.
package tmds_video_pkg;

  localparam int LEN_W = 16;

  typedef enum logic [1:0] {
    RGN_ACTIVE = 2'd0,
    RGN_FRONT  = 2'd1,
    RGN_SYNC   = 2'd2,
    RGN_BACK   = 2'd3
  } region_e;

  typedef struct packed {
    logic [LEN_W-1:0] active;
    logic [LEN_W-1:0] front;
    logic [LEN_W-1:0] sync;
    logic [LEN_W-1:0] back;
  } rgn_len_t;

  // TMDS control-period symbols indexed by {c1,c0}
  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

  function automatic logic [LEN_W-1:0] rgn_len(input region_e r, input rgn_len_t l);
    logic [LEN_W-1:0] len;
    case (r)
      RGN_ACTIVE: len = l.active;
      RGN_FRONT:  len = l.front;
      RGN_SYNC:   len = l.sync;
      default:    len = l.back;
    endcase
    return len;
  endfunction

  // Next region in ACTIVE->FRONT->SYNC->BACK order, skipping empty porch/sync
  // regions; running off the end of BACK lands on ACTIVE (axis wrap).
  function automatic region_e next_region(input region_e r, input rgn_len_t l);
    region_e n;
    region_e res;
    logic    done;
    n    = r;
    res  = RGN_ACTIVE;
    done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!done) begin
        n = region_e'(n + 2'd1);
        if (n == RGN_ACTIVE || rgn_len(n, l) != '0) begin
          res  = n;
          done = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/tmds_video_timing_axis.sv
// tmds_axis_fsm: one raster axis (horizontal or vertical). Tracks the
// current region, the position within it and the absolute count, and
// flags the last step of the axis period.
module tmds_axis_fsm import tmds_video_pkg::*; #(
  parameter int CW = 12
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_clr,
  input  logic          i_step,
  input  rgn_len_t      i_len,
  output region_e       o_region,
  output logic [CW-1:0] o_count,
  output logic          o_wrap
);

  localparam logic [CW-1:0] ONE = CW'(1);

  region_e       r_region;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_rcnt;
  logic [CW-1:0] w_len_m1;
  logic          w_rgn_end;
  region_e       w_next;

  assign w_len_m1  = CW'(rgn_len(r_region, i_len)) - ONE;
  assign w_rgn_end = (r_rcnt == w_len_m1);
  assign w_next    = next_region(r_region, i_len);
  assign o_wrap    = i_step && !i_clr && w_rgn_end && (w_next == RGN_ACTIVE);
  assign o_region  = r_region;
  assign o_count   = r_count;

  // Region/count advance: region changes only when its length is used up
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_region <= RGN_ACTIVE;
      r_count  <= '0;
      r_rcnt   <= '0;
    end else if (i_clr) begin
      r_region <= RGN_ACTIVE;
      r_count  <= '0;
      r_rcnt   <= '0;
    end else if (i_step) begin
      if (w_rgn_end) begin
        r_region <= w_next;
        r_rcnt   <= '0;
      end else begin
        r_rcnt   <= r_rcnt + ONE;
      end
      if (o_wrap) r_count <= '0;
      else        r_count <= r_count + ONE;
    end
  end

endmodule

// File: rtl/tmds_video_timing.sv
// tmds_video_timing: raster timing for the three TMDS channel encoders.
// Issues pix_req/x/y LEAD cycles ahead of de/hsync/vsync so frame-buffer
// read latency is hidden. Define TMDS_VIDEO_TIMING_CFG_EN to add runtime
// region lengths, applied only at frame boundaries.
module tmds_video_timing import tmds_video_pkg::*; #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int LEAD     = 1,
  parameter int CW       = 12
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
`ifdef TMDS_VIDEO_TIMING_CFG_EN
  input  logic [CW-1:0] cfg_h_active,
  input  logic [CW-1:0] cfg_h_fp,
  input  logic [CW-1:0] cfg_h_sync,
  input  logic [CW-1:0] cfg_h_bp,
  input  logic [CW-1:0] cfg_v_active,
  input  logic [CW-1:0] cfg_v_fp,
  input  logic [CW-1:0] cfg_v_sync,
  input  logic [CW-1:0] cfg_v_bp,
  input  logic          cfg_load,
`endif
  output logic          pix_req,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          frame_start,
  output logic          de,
  output logic          hsync,
  output logic          vsync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam rgn_len_t C_H_DEF = '{active: LEN_W'(H_ACTIVE), front: LEN_W'(H_FP),
                                   sync: LEN_W'(H_SYNC), back: LEN_W'(H_BP)};
  localparam rgn_len_t C_V_DEF = '{active: LEN_W'(V_ACTIVE), front: LEN_W'(V_FP),
                                   sync: LEN_W'(V_SYNC), back: LEN_W'(V_BP)};
  localparam logic [2:0] C_LATE_IDLE = {1'b0, ~H_POL, ~V_POL};

  if (H_TOTAL >= (1 << CW) || V_TOTAL >= (1 << CW) || LEAD < 0 || LEAD > 7 || CW > LEN_W)
  begin : g_bad_params
    $error("tmds_video_timing: totals must fit in CW bits and LEAD must be 0..7");
  end

  rgn_len_t      w_h_len;
  rgn_len_t      w_v_len;
  region_e       w_h_rgn;
  region_e       w_v_rgn;
  logic [CW-1:0] w_h_cnt;
  logic [CW-1:0] w_v_cnt;
  logic          w_h_wrap;
  logic          w_v_wrap;
  logic [2:0]    w_late;

  logic          r_pix_req_p0;
  logic          r_fs_p0;
  logic          r_hs_p0;
  logic          r_vs_p0;
  logic [CW-1:0] r_x_p0;
  logic [CW-1:0] r_y_p0;

`ifdef TMDS_VIDEO_TIMING_CFG_EN
  rgn_len_t r_h_act;
  rgn_len_t r_v_act;
  rgn_len_t r_h_pend;
  rgn_len_t r_v_pend;

  // Pending shadow captures cfg_load; active set switches only at frame wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h_act  <= C_H_DEF;
      r_v_act  <= C_V_DEF;
      r_h_pend <= C_H_DEF;
      r_v_pend <= C_V_DEF;
    end else begin
      if (w_h_wrap && w_v_wrap) begin
        r_h_act <= r_h_pend;
        r_v_act <= r_v_pend;
      end
      if (cfg_load) begin
        r_h_pend <= '{active: LEN_W'(cfg_h_active), front: LEN_W'(cfg_h_fp),
                      sync: LEN_W'(cfg_h_sync), back: LEN_W'(cfg_h_bp)};
        r_v_pend <= '{active: LEN_W'(cfg_v_active), front: LEN_W'(cfg_v_fp),
                      sync: LEN_W'(cfg_v_sync), back: LEN_W'(cfg_v_bp)};
      end
    end
  end

  assign w_h_len = r_h_act;
  assign w_v_len = r_v_act;
`else
  // Vertical wrap only feeds the runtime-config shadow
  logic w_unused_v_wrap;
  assign w_unused_v_wrap = w_v_wrap;
  assign w_h_len = C_H_DEF;
  assign w_v_len = C_V_DEF;
`endif

  tmds_axis_fsm #(.CW(CW)) u_h_axis (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clr    (~enable),
    .i_step   (1'b1),
    .i_len    (w_h_len),
    .o_region (w_h_rgn),
    .o_count  (w_h_cnt),
    .o_wrap   (w_h_wrap)
  );

  tmds_axis_fsm #(.CW(CW)) u_v_axis (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clr    (~enable),
    .i_step   (w_h_wrap),
    .i_len    (w_v_len),
    .o_region (w_v_rgn),
    .o_count  (w_v_cnt),
    .o_wrap   (w_v_wrap)
  );

  // Stage p0: early outputs registered from the counter state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pix_req_p0 <= 1'b0;
      r_fs_p0      <= 1'b0;
      r_hs_p0      <= ~H_POL;
      r_vs_p0      <= ~V_POL;
      r_x_p0       <= '0;
      r_y_p0       <= '0;
    end else if (!enable) begin
      r_pix_req_p0 <= 1'b0;
      r_fs_p0      <= 1'b0;
      r_hs_p0      <= ~H_POL;
      r_vs_p0      <= ~V_POL;
    end else begin
      r_pix_req_p0 <= (w_h_rgn == RGN_ACTIVE) && (w_v_rgn == RGN_ACTIVE);
      r_fs_p0      <= (w_h_cnt == '0) && (w_v_cnt == '0);
      r_hs_p0      <= (w_h_rgn == RGN_SYNC) ? H_POL : ~H_POL;
      r_vs_p0      <= (w_v_rgn == RGN_SYNC) ? V_POL : ~V_POL;
      if ((w_h_rgn == RGN_ACTIVE) && (w_v_rgn == RGN_ACTIVE)) begin
        r_x_p0 <= w_h_cnt;
        r_y_p0 <= w_v_cnt;
      end
    end
  end

  assign pix_req     = r_pix_req_p0;
  assign frame_start = r_fs_p0;
  assign x           = r_x_p0;
  assign y           = r_y_p0;

  // Stage p1: LEAD-deep delay of {de, hsync, vsync}
  if (LEAD == 0) begin : g_no_lead
    assign w_late = {r_pix_req_p0, r_hs_p0, r_vs_p0};
  end else begin : g_lead
    logic [2:0] r_dl_p1 [LEAD];

    // Shift register; idle values flow in while disabled
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < LEAD; i++) r_dl_p1[i] <= C_LATE_IDLE;
      end else begin
        r_dl_p1[0] <= {r_pix_req_p0, r_hs_p0, r_vs_p0};
        for (int i = 1; i < LEAD; i++) r_dl_p1[i] <= r_dl_p1[i-1];
      end
    end

    assign w_late = r_dl_p1[LEAD-1];
  end

  assign de    = w_late[2];
  assign hsync = w_late[1];
  assign vsync = w_late[0];

endmodule

// File: tb/tb_tmds_video_timing.sv
// Bench for tmds_video_timing: two instances (small timing with LEAD=2 and
// a zero-length-porch / positive-polarity variant with LEAD=0) checked
// every cycle against a raster model computed from linear frame position.
module tb_tmds_video_timing;

  localparam int CW = 12;

  logic clk = 1'b0;
  logic reset_n;
  logic enable;

  always #5 clk = ~clk;

  logic          pr [2];
  logic          fs [2];
  logic          de [2];
  logic          hs [2];
  logic          vs [2];
  logic [CW-1:0] xo [2];
  logic [CW-1:0] yo [2];

`ifdef TMDS_VIDEO_TIMING_CFG_EN
  logic [CW-1:0] c_ha, c_hf, c_hs, c_hb, c_va, c_vf, c_vs, c_vb;
  logic          c_load;
`endif

  tmds_video_timing #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .LEAD(2), .CW(CW)
  ) u_dut0 (
    .clk(clk), .reset_n(reset_n), .enable(enable),
`ifdef TMDS_VIDEO_TIMING_CFG_EN
    .cfg_h_active(c_ha), .cfg_h_fp(c_hf), .cfg_h_sync(c_hs), .cfg_h_bp(c_hb),
    .cfg_v_active(c_va), .cfg_v_fp(c_vf), .cfg_v_sync(c_vs), .cfg_v_bp(c_vb),
    .cfg_load(c_load),
`endif
    .pix_req(pr[0]), .x(xo[0]), .y(yo[0]), .frame_start(fs[0]),
    .de(de[0]), .hsync(hs[0]), .vsync(vs[0])
  );

  tmds_video_timing #(
    .H_ACTIVE(3), .H_FP(0), .H_SYNC(2), .H_BP(0),
    .V_ACTIVE(2), .V_FP(0), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .LEAD(0), .CW(CW)
  ) u_dut1 (
    .clk(clk), .reset_n(reset_n), .enable(enable),
`ifdef TMDS_VIDEO_TIMING_CFG_EN
    .cfg_h_active(12'd3), .cfg_h_fp(12'd0), .cfg_h_sync(12'd2), .cfg_h_bp(12'd0),
    .cfg_v_active(12'd2), .cfg_v_fp(12'd0), .cfg_v_sync(12'd1), .cfg_v_bp(12'd1),
    .cfg_load(1'b0),
`endif
    .pix_req(pr[1]), .x(xo[1]), .y(yo[1]), .frame_start(fs[1]),
    .de(de[1]), .hsync(hs[1]), .vsync(vs[1])
  );

  // Reference model: lengths {ha,hf,hs,hb,va,vf,vs,vb} per instance
  int       len_def [2][8] = '{'{4, 1, 2, 1, 3, 1, 1, 1}, '{3, 0, 2, 0, 2, 0, 1, 1}};
  int       lead_k  [2]    = '{2, 0};
  bit       hpol_k  [2]    = '{1'b0, 1'b1};
  bit       vpol_k  [2]    = '{1'b0, 1'b1};
  int       act     [2][8];
  int       pend    [2][8];
  int       cfg_now [8];
  int       mpos    [2];
  logic     m_pr    [2];
  logic     m_fs    [2];
  int       m_x     [2];
  int       m_y     [2];
  logic [2:0] hist  [2][8];

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // 0=active 1=front porch 2=sync 3=back porch, from position within the axis period
  function automatic int region_of(input int p, input int a, input int f, input int s);
    if (p < a)         return 0;
    if (p < a + f)     return 1;
    if (p < a + f + s) return 2;
    return 3;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s[u%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset(input int k);
    for (int i = 0; i < 8; i++) begin
      act[k][i]  = len_def[k][i];
      pend[k][i] = len_def[k][i];
      hist[k][i] = {1'b0, ~hpol_k[k], ~vpol_k[k]};
    end
    mpos[k] = 0;
    m_pr[k] = 1'b0;
    m_fs[k] = 1'b0;
    m_x[k]  = 0;
    m_y[k]  = 0;
  endtask

  task automatic model_step(input int k, input bit en, input bit ld);
    int ht, vt, h, v, hr, vr;
    logic [2:0] raw;
    if (en) begin
      ht = act[k][0] + act[k][1] + act[k][2] + act[k][3];
      vt = act[k][4] + act[k][5] + act[k][6] + act[k][7];
      h  = mpos[k] % ht;
      v  = mpos[k] / ht;
      hr = region_of(h, act[k][0], act[k][1], act[k][2]);
      vr = region_of(v, act[k][4], act[k][5], act[k][6]);
      m_pr[k] = (hr == 0) && (vr == 0);
      m_fs[k] = (mpos[k] == 0);
      if (m_pr[k]) begin
        m_x[k] = h;
        m_y[k] = v;
      end
      raw = {m_pr[k], (hr == 2) ? hpol_k[k] : ~hpol_k[k], (vr == 2) ? vpol_k[k] : ~vpol_k[k]};
      mpos[k]++;
      if (mpos[k] == ht * vt) begin
        mpos[k] = 0;
        for (int i = 0; i < 8; i++) act[k][i] = pend[k][i];
      end
    end else begin
      m_pr[k] = 1'b0;
      m_fs[k] = 1'b0;
      raw     = {1'b0, ~hpol_k[k], ~vpol_k[k]};
      mpos[k] = 0;
    end
    if (ld) for (int i = 0; i < 8; i++) pend[k][i] = cfg_now[i];
    for (int i = 7; i > 0; i--) hist[k][i] = hist[k][i-1];
    hist[k][0] = raw;
  endtask

  task automatic check_all(input int k);
    chk("pix_req",     k, 32'(pr[k]), 32'(m_pr[k]));
    chk("x",           k, 32'(xo[k]), 32'(m_x[k]));
    chk("y",           k, 32'(yo[k]), 32'(m_y[k]));
    chk("frame_start", k, 32'(fs[k]), 32'(m_fs[k]));
    chk("de",          k, 32'(de[k]), 32'(hist[k][lead_k[k]][2]));
    chk("hsync",       k, 32'(hs[k]), 32'(hist[k][lead_k[k]][1]));
    chk("vsync",       k, 32'(vs[k]), 32'(hist[k][lead_k[k]][0]));
  endtask

  task automatic tick();
    bit ld;
    @(posedge clk);
    ld = 1'b0;
`ifdef TMDS_VIDEO_TIMING_CFG_EN
    ld = c_load;
    cfg_now = '{int'(c_ha), int'(c_hf), int'(c_hs), int'(c_hb),
                int'(c_va), int'(c_vf), int'(c_vs), int'(c_vb)};
`endif
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) model_reset(k);
      else          model_step(k, enable, (k == 0) ? ld : 1'b0);
    end
    #1;
    for (int k = 0; k < 2; k++) check_all(k);
  endtask

  initial begin
    int cnt;
    bit seen;
    reset_n = 1'b0;
    enable  = 1'b1;
`ifdef TMDS_VIDEO_TIMING_CFG_EN
    {c_ha, c_hf, c_hs, c_hb} = {12'd4, 12'd1, 12'd2, 12'd1};
    {c_va, c_vf, c_vs, c_vb} = {12'd3, 12'd1, 12'd1, 12'd1};
    c_load = 1'b0;
`endif
    for (int k = 0; k < 2; k++) model_reset(k);

    // Reset held with enable high
    repeat (3) tick();
    chk("rst_de",      0, 32'(de[0]), 32'd0);
    chk("rst_hsync",   0, 32'(hs[0]), 32'd1);
    chk("rst_vsync",   0, 32'(vs[0]), 32'd1);
    chk("rst_pix_req", 0, 32'(pr[0]), 32'd0);
    chk("rst_x",       0, 32'(xo[0]), 32'd0);
    chk("rst_y",       0, 32'(yo[0]), 32'd0);

    // First cycle after release starts at origin
    reset_n = 1'b1;
    tick();
    chk("first_fs", 0, 32'(fs[0]), 32'd1);
    chk("first_pr", 0, 32'(pr[0]), 32'd1);
    chk("first_x",  0, 32'(xo[0]), 32'd0);
    chk("first_y",  0, 32'(yo[0]), 32'd0);

    // Two-plus frames free running
    repeat (110) tick();

    // Drop enable while counters sit at h=2, v=1
    for (int i = 0; i < 100 && mpos[0] != 10; i++) tick();
    enable = 1'b0;
    tick();
    chk("drop_pr", 0, 32'(pr[0]), 32'd0);
    repeat (2) tick();
    chk("drop_de", 0, 32'(de[0]), 32'd0);
    repeat (2) tick();
    enable = 1'b1;
    tick();
    chk("reen_fs", 0, 32'(fs[0]), 32'd1);
    chk("reen_x",  0, 32'(xo[0]), 32'd0);
    chk("reen_y",  0, 32'(yo[0]), 32'd0);

    // Asynchronous reset pulse at h=1, v=2
    for (int i = 0; i < 100 && mpos[0] != 17; i++) tick();
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      model_reset(k);
      check_all(k);
    end
    chk("arst_de",    0, 32'(de[0]), 32'd0);
    chk("arst_hsync", 0, 32'(hs[0]), 32'd1);
    chk("arst_pr",    0, 32'(pr[0]), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("arst_fs", 0, 32'(fs[0]), 32'd1);

    // Randomized enable traffic
    for (int i = 0; i < 400; i++) begin
      enable = ($urandom_range(15, 0) != 0);
      tick();
    end
    enable = 1'b1;
    repeat (60) tick();

`ifdef TMDS_VIDEO_TIMING_CFG_EN
    // Mid-frame H_ACTIVE change takes effect at the next frame only
    for (int i = 0; i < 100 && mpos[0] != 20; i++) tick();
    c_ha   = 12'd6;
    c_load = 1'b1;
    tick();
    c_load = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (fs[0] === 1'b1) seen = 1'b1;
    end
    chk("cfg_fs_seen", 0, 32'(seen), 32'd1);
    cnt = (pr[0] === 1'b1) ? 1 : 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (pr[0] === 1'b1) cnt++;
    end
    chk("cfg_line_px", 0, 32'(cnt), 32'd6);
    tick();
    chk("cfg_period_pr", 0, 32'(pr[0]), 32'd1);
    chk("cfg_period_x",  0, 32'(xo[0]), 32'd0);
    chk("cfg_period_y",  0, 32'(yo[0]), 32'd1);
    repeat (70) tick();
`else
    cnt  = 0;
    seen = 1'b0;
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
